dmem_sized: RTL
===============

# dmem_sized

Parametrised, byte-addressable, big-endian data memory for the 32-bit processor. It succeeds the fixed 4 KB word-only data memory: depth is a parameter, and accesses can be byte, halfword or word sized. Loads are sign- or zero-extended, and reads are registered with a valid strobe. Misaligned and out-of-range accesses are detected and reported instead of silently wrapping. It sits between the datapath's ALU address output and the write-back mux.

## Interface
- DEPTH_BYTES, 4096: byte capacity; power of two, ≥ 4.
- AW, 32: address width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- dm_cs  in  1  chip select.
- dm_wr  in  1  write request; qualified by dm_cs.
- dm_rd  in  1  read request; qualified by dm_cs.
- dm_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- dm_sign  in  1  load extension: 1 = sign-extend, 0 = zero-extend. Ignored for word loads and for writes.
- Addr  in  AW  byte address of the most-significant byte of the access.
- D_In  in  32  write data, right-justified: byte in [7:0], halfword in [15:0].
- D_Out  out  32  registered read data, right-justified and extended.
- dm_valid  out  1  one-cycle pulse: D_Out was updated by a successful read.
- dm_err  out  1  one-cycle pulse: the access sampled on the previous edge was rejected.

## Operation
- **Request:** a request is sampled on each rising clk when dm_cs=1 and (dm_wr | dm_rd).
- **Legality:**
  - Rejected if dm_size=11.
  - Rejected if a halfword has Addr[0]=1.
  - Rejected if a word has Addr[1:0]≠00.
  - Rejected if Addr > DEPTH_BYTES − nbytes, where nbytes is 1, 2 or 4.
  - A rejected request writes nothing, leaves D_Out unchanged, keeps dm_valid=0 and sets dm_err=1 for one cycle.
- **Write (big-endian):**
  - Byte: mem[A] ← D_In[7:0].
  - Halfword: mem[A] ← D_In[15:8], mem[A+1] ← D_In[7:0].
  - Word: mem[A..A+3] ← D_In[31:24], [23:16], [15:8], [7:0].
  - Bytes outside the access are untouched.
- **Read:**
  - Bytes are assembled big-endian from mem[A..], then zero- or sign-extended to 32 bits per dm_sign.
  - The result is registered into D_Out and dm_valid=1.
- **dm_wr and dm_rd both high:** the write commits and the read returns the pre-write contents (read-before-write). dm_valid=1.
- **No request or dm_cs=0:** D_Out holds its last value, and dm_valid=0 and dm_err=0.
- **Reset:**
  - D_Out=0, dm_valid=0, dm_err=0.
  - Memory contents are not cleared.
  - A read in flight when reset asserts is dropped, with no valid pulse after release.

## Timing
- Write latency: data is visible to a read sampled on the following edge.
- Read latency: 1 cycle. The request is sampled at edge N; D_Out and dm_valid are updated after edge N, for use in cycle N+1.
- Back-to-back requests every cycle are supported; there is no stall and no ready signal.
- dm_err follows the same 1-cycle latency as dm_valid. The two are never both 1.
- Reset is asynchronous on assert. Outputs go to their reset values without waiting for clk.

## Structure
- **Shared package `dmem_pkg`:**
  - Constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11.
  - Function nbytes(size).
- **Sub-module `dmem_load_fmt` (combinational):**
  - Inputs: the 4 raw bytes, dm_size, dm_sign.
  - Output: the extended 32-bit word.
  - Reused by the future I-cache fill path.
- **Top level:** legality check, byte-array write, read register, and valid/err flops.

## Test plan
- Word write 0xDEADBEEF @0x10, then word read @0x10 → next cycle D_Out=0xDEADBEEF, dm_valid=1. Byte read @0x10 with dm_sign=0 → 0x000000DE.
- Byte read @0x13 with dm_sign=1 → 0xFFFFFFEF. Halfword read @0x12 with dm_sign=1 → 0xFFFFBEEF; with dm_sign=0 → 0x0000BEEF.
- Byte write 0x55 @0x11, then word read @0x10 → 0xDE55BEEF. Halfword write 0x1234 @0x12, then word read → 0xDE551234.
- Each of these gives dm_err=1, dm_valid=0, D_Out unchanged and memory unchanged:
  - word @0x11;
  - halfword @0x13;
  - dm_size=11;
  - word @DEPTH_BYTES−2;
  - byte @DEPTH_BYTES.
- Same-cycle rd+wr @0x20 (old 0x0, new 0xA5A5A5A5) → D_Out=0x00000000. A following read → 0xA5A5A5A5.
- Assert reset mid-stream after a read request and before the edge → D_Out=0 and dm_valid=0 immediately, with no pulse after release. Memory still holds the earlier writes.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the sized data memory and its load formatter.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // The reserved size reports 4 bytes; it is rejected before the count matters.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Right-justifies big-endian load bytes and applies sign or zero extension.
module dmem_load_fmt
    import dmem_pkg::*;
(
    input  logic [7:0]  i_b0,
    input  logic [7:0]  i_b1,
    input  logic [7:0]  i_b2,
    input  logic [7:0]  i_b3,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    output logic [31:0] o_word
);

    logic w_msb;

    // i_b0 always holds the most-significant byte of the access.
    assign w_msb = i_sign & i_b0[7];

    always_comb begin
        o_word = {i_b0, i_b1, i_b2, i_b3};
        case (i_size)
            SZ_BYTE: o_word = {{24{w_msb}}, i_b0};
            SZ_HALF: o_word = {{16{w_msb}}, i_b0, i_b1};
            default: o_word = {i_b0, i_b1, i_b2, i_b3};
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressable big-endian data memory with sized accesses, registered reads
// and one-cycle valid/error strobes.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 4096,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dm_cs,
    input  logic          dm_wr,
    input  logic          dm_rd,
    input  logic [1:0]    dm_size,
    input  logic          dm_sign,
    input  logic [AW-1:0] Addr,
    input  logic [31:0]   D_In,
    output logic [31:0]   D_Out,
    output logic          dm_valid,
    output logic          dm_err
);

    localparam int IW = $clog2(DEPTH_BYTES);
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH_BYTES);

    // No ready: every sampled request completes; dm_valid or dm_err pulses
    // on the cycle after the sampling edge, never both.
    logic [7:0]    r_mem [DEPTH_BYTES];

    logic          w_req;
    logic          w_misalign;
    logic          w_range_err;
    logic          w_legal;
    logic          w_do_wr;
    logic [AW:0]   w_limit;
    logic [IW-1:0] w_i0;
    logic [IW-1:0] w_i1;
    logic [IW-1:0] w_i2;
    logic [IW-1:0] w_i3;
    logic [31:0]   w_load;

    assign w_req       = dm_cs & (dm_wr | dm_rd);
    assign w_misalign  = ((dm_size == SZ_HALF) & Addr[0]) |
                         ((dm_size == SZ_WORD) & (Addr[1:0] != 2'b00));
    assign w_limit     = DEPTH_EXT - (AW+1)'(nbytes(dm_size));
    assign w_range_err = {1'b0, Addr} > w_limit;
    assign w_legal     = (dm_size != SZ_RSVD) & ~w_misalign & ~w_range_err;
    assign w_do_wr     = w_req & w_legal & dm_wr & ~reset;

    // Indices only matter for legal accesses, which never cross the top.
    assign w_i0 = Addr[IW-1:0];
    assign w_i1 = w_i0 + IW'(1);
    assign w_i2 = w_i0 + IW'(2);
    assign w_i3 = w_i0 + IW'(3);

    dmem_load_fmt u_fmt (
        .i_b0   (r_mem[w_i0]),
        .i_b1   (r_mem[w_i1]),
        .i_b2   (r_mem[w_i2]),
        .i_b3   (r_mem[w_i3]),
        .i_size (dm_size),
        .i_sign (dm_sign),
        .o_word (w_load)
    );

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            case (dm_size)
                SZ_BYTE: r_mem[w_i0] <= D_In[7:0];
                SZ_HALF: begin
                    r_mem[w_i0] <= D_In[15:8];
                    r_mem[w_i1] <= D_In[7:0];
                end
                default: begin
                    r_mem[w_i0] <= D_In[31:24];
                    r_mem[w_i1] <= D_In[23:16];
                    r_mem[w_i2] <= D_In[15:8];
                    r_mem[w_i3] <= D_In[7:0];
                end
            endcase
        end
    end

    // The read mux sees pre-edge contents, giving read-before-write on rd+wr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            D_Out    <= 32'h0;
            dm_valid <= 1'b0;
            dm_err   <= 1'b0;
        end else begin
            dm_valid <= 1'b0;
            dm_err   <= 1'b0;
            if (w_req) begin
                if (!w_legal) begin
                    dm_err <= 1'b1;
                end else if (dm_rd) begin
                    D_Out    <= w_load;
                    dm_valid <= 1'b1;
                end
            end
        end
    end

endmodule
